// File: rtl/dmux8way16_frame_pkg.sv
// Shared definitions for the dmux8way16_frame word-to-frame assembler.
// Holds the frame FSM state type and the default geometry constants.
// The early-close feature is compiled in with DMUX8WAY16_FLUSH_EN.
package dmux8way16_frame_pkg;

    // FILL: collecting words into lanes; FULL: frame presented, input stalled.
    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_LANES = 8;

endpackage : dmux8way16_frame_pkg

// File: rtl/dmux8way16_frame_lane_decoder.sv
// Write-side demultiplexer for dmux8way16_frame.
// Turns the current lane index plus a write enable into a one-hot lane
// write-enable vector. With DMUX8WAY16_FLUSH_EN it also produces the mask of
// lanes above the index, used to zero the unused tail of a short frame.
module dmux_lane_decoder
    import dmux8way16_frame_pkg::*;
#(
    parameter int NUM_LANES = DEFAULT_LANES,
    parameter int IDX_W     = $clog2(NUM_LANES)
) (
    input  logic [IDX_W-1:0]     idx,
    input  logic                 wr_en,
`ifdef DMUX8WAY16_FLUSH_EN
    input  logic                 last_en,
    output logic [NUM_LANES-1:0] clear_mask,
`endif
    output logic [NUM_LANES-1:0] wr_onehot
);

    // One-hot write enable: only the lane addressed by idx is written.
    always_comb begin
        wr_onehot = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            wr_onehot[k] = wr_en && (idx == IDX_W'(k));
        end
    end

`ifdef DMUX8WAY16_FLUSH_EN
    // Lanes strictly above the closing word are cleared when a frame ends early.
    always_comb begin
        clear_mask = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            clear_mask[k] = last_en && (IDX_W'(k) > idx);
        end
    end
`endif

endmodule : dmux_lane_decoder

// File: rtl/dmux8way16_frame.sv
// dmux8way16_frame: accepts a stream of WIDTH-bit words on a valid/ready input
// and distributes them round-robin into NUM_LANES lane registers (lane 0
// first), then presents the assembled frame on a valid/ready output.
// Optional feature macro: DMUX8WAY16_FLUSH_EN adds in_last to close a frame
// early; unused upper lanes are zeroed and out_count reports the words used.
module dmux8way16_frame
    import dmux8way16_frame_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int NUM_LANES = DEFAULT_LANES,
    parameter int IDX_W     = $clog2(NUM_LANES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
`ifdef DMUX8WAY16_FLUSH_EN
    input  logic                       in_last,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH*NUM_LANES-1:0] out_data,
    output logic [IDX_W:0]             out_count
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_LANES - 1);
    localparam logic [IDX_W:0]   FULL_CNT  = (IDX_W+1)'(NUM_LANES);

    state_e                                  state_q, state_d;
    logic [IDX_W-1:0]                        idx_q, idx_d;
    logic [NUM_LANES-1:0][WIDTH-1:0]         lanes_q, lanes_d;
    logic                                    out_valid_q, out_valid_d;
    logic [IDX_W:0]                          out_count_q, out_count_d;

    logic                                    accept;
    logic                                    release_frame;
    logic                                    close_frame;
    logic [NUM_LANES-1:0]                    wr_onehot;
`ifdef DMUX8WAY16_FLUSH_EN
    logic [NUM_LANES-1:0]                    clear_mask;
`endif

    // Handshake terms; in_ready depends on state only, never on in_valid/out_ready.
    always_comb begin
        in_ready      = (state_q == FILL);
        accept        = in_valid && in_ready;
        release_frame = out_valid_q && out_ready;
`ifdef DMUX8WAY16_FLUSH_EN
        close_frame   = accept && ((idx_q == LAST_IDX) || in_last);
`else
        close_frame   = accept && (idx_q == LAST_IDX);
`endif
    end

    dmux_lane_decoder #(
        .NUM_LANES (NUM_LANES),
        .IDX_W     (IDX_W)
    ) u_lane_decoder (
        .idx        (idx_q),
        .wr_en      (accept),
`ifdef DMUX8WAY16_FLUSH_EN
        .last_en    (accept && in_last),
        .clear_mask (clear_mask),
`endif
        .wr_onehot  (wr_onehot)
    );

    // Next-state logic: lane writes, index advance, frame close and release.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lanes_d     = lanes_q;
        out_valid_d = out_valid_q;
        out_count_d = out_count_q;

        case (state_q)
            FILL: begin
                if (accept) begin
                    for (int k = 0; k < NUM_LANES; k++) begin
                        if (wr_onehot[k]) begin
                            lanes_d[k] = in_data;
                        end
`ifdef DMUX8WAY16_FLUSH_EN
                        if (clear_mask[k]) begin
                            lanes_d[k] = '0;
                        end
`endif
                    end
                    if (close_frame) begin
                        // idx+1 equals NUM_LANES for a normal frame, fewer on early close.
                        state_d     = FULL;
                        out_valid_d = 1'b1;
                        out_count_d = {1'b0, idx_q} + (IDX_W+1)'(1);
                        idx_d       = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            FULL: begin
                // Lanes are not cleared on release; they are overwritten word by word.
                if (release_frame) begin
                    state_d     = FILL;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = FILL;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State, index, lane and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            idx_q       <= '0;
            lanes_q     <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lanes_q     <= lanes_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign out_data  = lanes_q;

    // Keeps the constant referenced in builds where the close path uses idx+1.
    logic unused_full_cnt;
    assign unused_full_cnt = ^FULL_CNT;

endmodule : dmux8way16_frame

// File: tb/tb_dmux8way16_frame.sv
// Directed bench for dmux8way16_frame with a frame-level reference model and
// a per-cycle compare process. Build with DMUX8WAY16_FLUSH_EN to add the
// early-close scenario.
module tb_dmux8way16_frame;

    localparam int W = 16;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_data = '0;
    logic           in_last_r = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W*N-1:0] out_data;
    logic [3:0]     out_count;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    dmux8way16_frame #(.WIDTH(W), .NUM_LANES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef DMUX8WAY16_FLUSH_EN
        .in_last   (in_last_r),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    // Reference model: words counted per frame, k-th word goes to lane k.
    logic [W-1:0] m_lane [N];
    int           m_n;
    bit           m_full;
    int           m_cnt;
    bit           m_last;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) m_lane[k] = '0;
            m_n = 0; m_full = 1'b0; m_cnt = 0;
        end else if (!m_full) begin
            if (in_valid) begin
`ifdef DMUX8WAY16_FLUSH_EN
                m_last = in_last_r;
`else
                m_last = 1'b0;
`endif
                m_lane[m_n] = in_data;
                m_n = m_n + 1;
                if (m_n == N || m_last) begin
                    if (m_last) for (int k = m_n; k < N; k++) m_lane[k] = '0;
                    m_cnt = m_n;
                    m_n = 0;
                    m_full = 1'b1;
                end
            end
        end else if (out_ready) begin
            m_full = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [W*N-1:0] act, input logic [W*N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [W*N-1:0] exp_data;
        if (chk_en) begin
            for (int k = 0; k < N; k++) exp_data[k*W +: W] = m_lane[k];
            chk("cyc_in_ready",  {127'd0, in_ready},  {127'd0, !m_full});
            chk("cyc_out_valid", {127'd0, out_valid}, {127'd0, m_full});
            chk("cyc_out_data",  out_data, exp_data);
            chk("cyc_out_count", {124'd0, out_count}, (W*N)'(m_cnt));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] w, input logic last);
        int b = 0;
        in_valid = 1'b1; in_data = w; in_last_r = last;
        while (!in_ready && b < 50) begin cycle(); b++; end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL push_timeout actual=in_ready_low required=in_ready_high");
        end
        cycle();
        in_valid = 1'b0; in_last_r = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W*N-1:0] frame_bp;

        // Reset held 3 cycles with in_valid asserted.
        in_valid = 1'b1; in_data = 16'hDEAD;
        rst_n = 1'b0;
        repeat (3) cycle();
        chk_en = 1'b1;
        chk("rst_in_ready",  {127'd0, in_ready},  128'd1);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_out_data",  out_data, 128'd0);
        chk("rst_out_count", {124'd0, out_count}, 128'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        cycle();
        chk("rst_no_lane_written", out_data, 128'd0);

        // Full frame back-to-back with out_ready high.
        out_ready = 1'b1;
        for (int k = 0; k < N - 1; k++) push(16'h1111 * (k + 1), 1'b0);
        chk("full_not_yet_valid", {127'd0, out_valid}, 128'd0);
        push(16'h8888, 1'b0);
        chk("full_valid_after_8", {127'd0, out_valid}, 128'd1);
        chk("full_lane0", {112'd0, out_data[15:0]}, {112'd0, 16'h1111});
        chk("full_lane7", {112'd0, out_data[127:112]}, {112'd0, 16'h8888});
        chk("full_count", {124'd0, out_count}, 128'd8);
        chk("full_in_ready_low", {127'd0, in_ready}, 128'd0);
        cycle();
        chk("full_in_ready_back", {127'd0, in_ready}, 128'd1);
        chk("full_lanes_kept", {112'd0, out_data[31:16]}, {112'd0, 16'h2222});

        // Back-pressure: frame held 10 cycles while the producer offers 0xAAAA.
        out_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            frame_bp[k*W +: W] = 16'h0101 * (k + 1);
            push(16'h0101 * (k + 1), 1'b0);
        end
        in_valid = 1'b1; in_data = 16'hAAAA;
        for (int c = 0; c < 10; c++) begin
            chk("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
            chk("bp_data_stable", out_data, frame_bp);
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_no_bypass", out_data, frame_bp);
        chk("bp_ready_after_release", {127'd0, in_ready}, 128'd1);
        cycle();
        in_valid = 1'b0;
        chk("bp_aaaa_lane0", {112'd0, out_data[15:0]}, {112'd0, 16'hAAAA});
        chk("bp_lane1_old", {112'd0, out_data[31:16]}, {112'd0, 16'h0202});
        for (int k = 1; k < N; k++) push(16'h3000 + 16'(k), 1'b0);
        chk("bp_frame2_lane7", {112'd0, out_data[127:112]}, {112'd0, 16'h3007});
        cycle();

        // Bubbles: in_valid alternating, 8 accepts over 16 cycles.
        out_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            in_valid = (c % 2 == 0);
            in_data  = 16'h2000 + 16'(c / 2);
            cycle();
        end
        in_valid = 1'b0;
        chk("bub_valid", {127'd0, out_valid}, 128'd1);
        chk("bub_lane0", {112'd0, out_data[15:0]}, {112'd0, 16'h2000});
        chk("bub_lane3", {112'd0, out_data[63:48]}, {112'd0, 16'h2003});
        chk("bub_lane7", {112'd0, out_data[127:112]}, {112'd0, 16'h2007});
        out_ready = 1'b1;
        cycle();

        // Asynchronous reset after 5 accepts, asserted between edges.
        for (int k = 0; k < 5; k++) push(16'h4000 + 16'(k), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_data_clear", out_data, 128'd0);
        chk("arst_valid", {127'd0, out_valid}, 128'd0);
        chk("arst_ready", {127'd0, in_ready}, 128'd1);
        chk("arst_count", {124'd0, out_count}, 128'd0);
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) push(16'h5000 + 16'(k), 1'b0);
        chk("arst_frame_valid", {127'd0, out_valid}, 128'd1);
        chk("arst_frame_lane0", {112'd0, out_data[15:0]}, {112'd0, 16'h5000});
        chk("arst_frame_lane7", {112'd0, out_data[127:112]}, {112'd0, 16'h5007});
        cycle();

`ifdef DMUX8WAY16_FLUSH_EN
        // Early close after three words; upper lanes forced to zero.
        out_ready = 1'b0;
        push(16'h0001, 1'b0);
        push(16'h0002, 1'b0);
        push(16'h0003, 1'b1);
        chk("fl_valid", {127'd0, out_valid}, 128'd1);
        chk("fl_count", {124'd0, out_count}, 128'd3);
        chk("fl_data", out_data, {80'd0, 16'h0003, 16'h0002, 16'h0001});
        out_ready = 1'b1;
        cycle();
        push(16'h0BEE, 1'b0);
        chk("fl_next_lane0", {112'd0, out_data[15:0]}, {112'd0, 16'h0BEE});
        chk("fl_next_lane1", {112'd0, out_data[31:16]}, {112'd0, 16'h0002});
        for (int k = 1; k < N; k++) push(16'h6000 + 16'(k), 1'b0);
        chk("fl_next_count", {124'd0, out_count}, 128'd8);
        cycle();
`endif

        out_ready = 1'b0;
        cycle();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dmux8way16_frame
